// File: rtl/fsqrt_pkg.sv
// Shared types, constants and helpers for the iterative binary32 square root.
//
// Contents:
//   state_t          FSM states (IDLE, ITER, ROUND, DONE)
//   QNAN_DEF         canonical quiet NaN for invalid operations
//   EXP_BIAS         binary32 exponent bias
//   ROOT_W / RAD_W   root and radicand widths of the digit recurrence
//   REM_W            partial remainder width (holds up to 2*root+1 plus two shifted-in bits)
//   is_special()     operand bypasses the recurrence (zero/subnormal, negative, inf, NaN)
//   special_result() {invalid, result} for a special operand
package fsqrt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] QNAN_DEF = 32'h7FC00000;
  localparam int          EXP_BIAS = 127;
  localparam int          ROOT_W   = 25;
  localparam int          RAD_W    = 50;
  localparam int          REM_W    = 28;

  function automatic logic is_special(input logic [31:0] x);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || x[31];
  endfunction

  // Priority matters: NaN first, then zero/subnormal (keeps the sign, so
  // -0 and negative subnormals are not invalid), then negative, then +inf.
  function automatic logic [32:0] special_result(input logic [31:0] x,
                                                 input logic [31:0] qnan);
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return {1'b1, qnan};
    if (x[30:23] == 8'h00)                     return {1'b0, x[31], 31'd0};
    if (x[31])                                 return {1'b1, qnan};
    return {1'b0, x};
  endfunction

endpackage

// File: rtl/fsqrt_iter_if.sv
// Operand/result handshake bundle for fsqrt_iter.
//
// Signals:
//   in_valid/in_ready/op                       operand channel (issue logic -> sqrt)
//   out_valid/out_ready/result/flag_*          result channel  (sqrt -> consumer)
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both 1. The producer keeps valid and its payload stable until that edge;
// the consumer may drive ready freely and need not wait for valid.
//
// Modports: slave = the square-root unit, master = the driving logic.
interface fsqrt_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_invalid;
  logic        flag_inexact;

  modport slave (
    input  in_valid, op, out_ready,
    output in_ready, out_valid, result, flag_invalid, flag_inexact
  );

  modport master (
    output in_valid, op, out_ready,
    input  in_ready, out_valid, result, flag_invalid, flag_inexact
  );
endinterface

// File: rtl/fsqrt_root_step.sv
// One radix-2 restoring square-root step (purely combinational).
//
// Ports:
//   rem_i   partial remainder before the step
//   root_i  partial root before the step
//   rad_i   next two radicand bits, MSB first
//   rem_o   partial remainder after the step
//   bit_o   new root bit (1 when the trial subtraction does not borrow)
module fsqrt_root_step
  import fsqrt_pkg::*;
#(
  parameter int REM_BITS  = REM_W,
  parameter int ROOT_BITS = ROOT_W
) (
  input  logic [REM_BITS-1:0]  rem_i,
  input  logic [ROOT_BITS-1:0] root_i,
  input  logic [1:0]           rad_i,
  output logic [REM_BITS-1:0]  rem_o,
  output logic                 bit_o
);
  logic [REM_BITS+1:0] shifted;
  logic [REM_BITS+1:0] trial;

  assign shifted = {rem_i, rad_i};
  assign trial   = {{(REM_BITS - ROOT_BITS){1'b0}}, root_i, 2'b01};

  // Full-width compare decides the bit; the difference itself always fits in
  // REM_BITS because a restored remainder never exceeds twice the root.
  assign bit_o = (shifted >= trial);
  assign rem_o = bit_o ? (shifted[REM_BITS-1:0] - trial[REM_BITS-1:0])
                       : shifted[REM_BITS-1:0];
endmodule

// File: rtl/fsqrt_iter.sv
// Multi-cycle IEEE-754 binary32 square root, round-to-nearest-even, DAZ/FTZ.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high; discards any operation in flight
//   bus      fsqrt_iter_if.slave: operand and result valid/ready channels
//   state_o  current FSM state (debug visibility)
//
// Parameters:
//   BITS_PER_CYCLE  root bits per ITER cycle (1, 5 or 25)
//   QNAN            value returned for invalid operations
//
// Normal operands walk IDLE -> ITER (N_ITER cycles) -> ROUND -> DONE.
// Special operands are resolved at accept and spend one cycle in IDLE with
// in_ready low before moving to DONE, so they answer one edge after accept.
module fsqrt_iter
  import fsqrt_pkg::*;
#(
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] QNAN           = QNAN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  fsqrt_iter_if.slave bus,
  output state_t      state_o
);
  localparam int N_ITER = ROOT_W / BITS_PER_CYCLE;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 5 || BITS_PER_CYCLE == 25)) begin : g_bad_bpc
    $error("fsqrt_iter: BITS_PER_CYCLE must be 1, 5 or 25");
  end

  state_t             state_q, state_d;
  logic               pend_q, pend_d;    // special result waiting to be presented
  logic [RAD_W-1:0]   rad_q, rad_d;      // unconsumed radicand bits, MSB aligned
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [ROOT_W-1:0]  root_q, root_d;
  logic [7:0]         er_q, er_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic               inv_q, inv_d;
  logic               inx_q, inx_d;

  // ---------------- recurrence chain ----------------
  logic [REM_W-1:0]  rem_c  [BITS_PER_CYCLE+1];
  logic [ROOT_W-1:0] root_c [BITS_PER_CYCLE+1];
  logic              bit_c  [BITS_PER_CYCLE];

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    fsqrt_root_step #(
      .REM_BITS (REM_W),
      .ROOT_BITS(ROOT_W)
    ) u_step (
      .rem_i (rem_c[g]),
      .root_i(root_c[g]),
      .rad_i (rad_q[RAD_W-1-2*g -: 2]),
      .rem_o (rem_c[g+1]),
      .bit_o (bit_c[g])
    );
    assign root_c[g+1] = {root_c[g][ROOT_W-2:0], bit_c[g]};
  end

  // ---------------- rounding ----------------
  logic        g_bit, s_bit, rnd_up;
  logic [23:0] mant_sum;
  logic [7:0]  er_fin;
  logic [8:0]  er_sum;

  assign g_bit    = root_q[0];
  assign s_bit    = |rem_q;
  assign rnd_up   = g_bit & (s_bit | root_q[1]);
  assign mant_sum = {1'b0, root_q[23:1]} + {23'd0, rnd_up};
  // Mantissa overflow renormalises to 1.0 x 2^(er+1): fraction bits become zero.
  assign er_fin   = er_q + {7'd0, mant_sum[23]};
  assign er_sum   = {1'b0, bus.op[30:23]} + 9'(EXP_BIAS);

  // ---------------- handshake ----------------
  logic accept;
  assign bus.in_ready     = (state_q == IDLE) && !pend_q && !reset;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.result       = res_q;
  assign bus.flag_invalid = inv_q;
  assign bus.flag_inexact = inx_q;
  assign state_o          = state_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      er_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      er_q    <= er_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      inx_q   <= inx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    er_d    = er_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    inv_d   = inv_q;
    inx_d   = inx_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = DONE;
        end else if (accept) begin
          if (is_special(bus.op)) begin
            {inv_d, res_d} = special_result(bus.op, QNAN);
            inx_d          = 1'b0;
            pend_d         = 1'b1;
          end else begin
            // Odd biased exponent -> even true exponent: radicand in [1,2).
            // Even biased exponent: pre-multiply by 2 so the exponent halves exactly.
            rad_d   = bus.op[23] ? {2'b01, bus.op[22:0], 25'd0}
                                 : {1'b1,  bus.op[22:0], 26'd0};
            rem_d   = '0;
            root_d  = '0;
            er_d    = 8'(er_sum >> 1);
            cnt_d   = '0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d  = rem_c[BITS_PER_CYCLE];
        root_d = root_c[BITS_PER_CYCLE];
        rad_d  = rad_q << (2 * BITS_PER_CYCLE);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_ITER - 1)) state_d = ROUND;
      end
      ROUND: begin
        res_d   = {1'b0, er_fin, mant_sum[22:0]};
        inv_d   = 1'b0;
        inx_d   = g_bit | s_bit;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fsqrt_iter.sv
// Self-checking bench for fsqrt_iter: three instances (1, 5 and 25 root bits
// per cycle) share the stimulus variables; `sel` picks which one is driven.
module tb_fsqrt_iter;
  import fsqrt_pkg::*;

  localparam logic [31:0] QNAN_TB = 32'h7FC00000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic        in_valid;
  logic        out_ready;
  logic [31:0] op;
  int          sel;

  fsqrt_iter_if if1 ();
  fsqrt_iter_if if5 ();
  fsqrt_iter_if if25 ();
  state_t st1, st5, st25;

  fsqrt_iter #(.BITS_PER_CYCLE(1))  dut1  (.clk(clk), .reset(reset), .bus(if1),  .state_o(st1));
  fsqrt_iter #(.BITS_PER_CYCLE(5))  dut5  (.clk(clk), .reset(reset), .bus(if5),  .state_o(st5));
  fsqrt_iter #(.BITS_PER_CYCLE(25)) dut25 (.clk(clk), .reset(reset), .bus(if25), .state_o(st25));

  assign if1.in_valid   = in_valid && (sel == 0);
  assign if5.in_valid   = in_valid && (sel == 1);
  assign if25.in_valid  = in_valid && (sel == 2);
  assign if1.op         = op;
  assign if5.op         = op;
  assign if25.op        = op;
  assign if1.out_ready  = out_ready;
  assign if5.out_ready  = out_ready;
  assign if25.out_ready = out_ready;

  logic        cur_in_ready, cur_out_valid, cur_inv, cur_inx;
  logic [31:0] cur_res;
  state_t      cur_st;
  always_comb begin
    case (sel)
      1: begin
        cur_in_ready = if5.in_ready;  cur_out_valid = if5.out_valid;
        cur_res = if5.result; cur_inv = if5.flag_invalid; cur_inx = if5.flag_inexact; cur_st = st5;
      end
      2: begin
        cur_in_ready = if25.in_ready; cur_out_valid = if25.out_valid;
        cur_res = if25.result; cur_inv = if25.flag_invalid; cur_inx = if25.flag_inexact; cur_st = st25;
      end
      default: begin
        cur_in_ready = if1.in_ready;  cur_out_valid = if1.out_valid;
        cur_res = if1.result; cur_inv = if1.flag_invalid; cur_inx = if1.flag_inexact; cur_st = st1;
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (sel=%0d op=%h): got %h expected %h", name, sel, op, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit tb_special(input logic [31:0] a);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || a[31];
  endfunction

  // Returns {invalid, inexact, result}: exact integer square root of the
  // scaled significand, then round-to-nearest-even on the half-ULP bit.
  function automatic logic [33:0] ref_sqrt(input logic [31:0] a);
    int     e;
    longint m, x, lo, hi, mid, q, rem, r, bits;
    bit     g, up;
    e = int'(a[30:23]);
    if (e == 255 && a[22:0] != 23'd0) return {2'b10, QNAN_TB};
    if (e == 0)                       return {2'b00, a[31], 31'd0};
    if (a[31])                        return {2'b10, QNAN_TB};
    if (e == 255)                     return {2'b00, a};
    m  = 64'd8388608 + longint'(a[22:0]);
    x  = (e % 2 == 1) ? (m << 25) : (m << 26);
    lo = 0;
    hi = 33554431;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid - 1;
    end
    q    = lo;
    rem  = x - q * q;
    g    = (q % 2) == 1;
    up   = g && (rem != 0 || ((q / 2) % 2) == 1);
    r    = q / 2 + (up ? 1 : 0);
    bits = longint'((e + 127) / 2) * 8388608 + (r - 8388608);
    return {1'b0, (g || rem != 0), bits[31:0]};
  endfunction

  function automatic int exp_lat(input int s, input bit special);
    if (special) return 1;
    case (s)
      1:       return 6;
      2:       return 2;
      default: return 26;
    endcase
  endfunction

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic wait_in_ready();
    int n = 0;
    while (!cur_in_ready && n < 200) begin @(negedge clk); n++; end
    check("in_ready_timeout", cur_in_ready, 1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!cur_out_valid && n < 200) begin @(negedge clk); n++; end
    check("out_valid_timeout", cur_out_valid, 1);
  endtask

  task automatic run_op(input logic [31:0] x, input int hold,
                        output logic [31:0] r, output logic inv, output logic inx,
                        output int lat);
    int t0;
    out_ready = 1'b0;
    op        = x;
    in_valid  = 1'b1;
    wait_in_ready();
    @(posedge clk);
    @(negedge clk);
    t0       = cyc;
    in_valid = 1'b0;
    op       = $urandom();   // operand must not be re-read after accept
    wait_out_valid();
    lat = cyc - t0;
    r   = cur_res;
    inv = cur_inv;
    inx = cur_inx;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] gen_op();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 7))
      0, 1: begin v[31] = 1'b0; v[30:23] = 8'hFE; end
      2: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) v[22:0] = '0; end
      3: v[30:23] = 8'h00;
      4: begin v[31] = 1'b0; v[30:23] = 8'h01; end
      5: v[31] = 1'b1;
      default: v[31] = 1'b0;
    endcase
    return v;
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    bit          special;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    logic [31:0] r, r0;
    logic        inv, inx, inv0, inx0;
    int          lat, bad, seen;
    logic [33:0] m;

    vecs[0]  = '{32'h40800000, 32'h40000000, 1'b0, 1'b0, 1'b0};  // 4.0
    vecs[1]  = '{32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 1'b0};  // 2.0
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};  // 1.0
    vecs[3]  = '{32'h41100000, 32'h40400000, 1'b0, 1'b0, 1'b0};  // 9.0
    vecs[4]  = '{32'h7F7FFFFF, 32'h5F7FFFFF, 1'b0, 1'b1, 1'b0};  // max normal
    vecs[5]  = '{32'h00800000, 32'h20000000, 1'b0, 1'b0, 1'b0};  // min normal
    vecs[6]  = '{32'hBF800000, QNAN_TB,      1'b1, 1'b0, 1'b1};  // -1.0
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1};  // -0
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 1'b1};  // +inf
    vecs[9]  = '{32'h7FA00001, QNAN_TB,      1'b1, 1'b0, 1'b1};  // sNaN
    vecs[10] = '{32'h00400000, 32'h00000000, 1'b0, 1'b0, 1'b1};  // subnormal
    vecs[11] = '{32'hFF800000, QNAN_TB,      1'b1, 1'b0, 1'b1};  // -inf
    vecs[12] = '{32'h80400000, 32'h80000000, 1'b0, 1'b0, 1'b1};  // -subnormal

    // ---- reset state; in_valid during reset is ignored ----
    sel       = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    op        = 32'h40800000;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  cur_in_ready, 0);
    check("rst_out_valid", cur_out_valid, 0);
    check("rst_result",    cur_res, 0);
    check("rst_flags",     {cur_inv, cur_inx}, 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  cur_in_ready, 1);
    check("post_rst_out_valid", cur_out_valid, 0);
    check("post_rst_state",     cur_st, IDLE);

    // ---- directed table on every instance ----
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < NV; i++) begin
        run_op(vecs[i].op, 0, r, inv, inx, lat);
        check("vec_result",  r,   vecs[i].res);
        check("vec_invalid", inv, vecs[i].inv);
        check("vec_inexact", inx, vecs[i].inx);
        check("vec_latency", lat, exp_lat(s, vecs[i].special));
      end
    end

    // ---- backpressure: result held 10 cycles, next op waits ----
    sel       = 0;
    out_ready = 1'b0;
    op        = 32'h40000000;
    in_valid  = 1'b1;
    wait_in_ready();
    @(posedge clk);
    @(negedge clk);
    op = 32'h41100000;          // keep in_valid high: must wait, not be taken
    wait_out_valid();
    r0 = cur_res; inv0 = cur_inv; inx0 = cur_inx;
    check("bp_result", r0, 32'h3FB504F3);
    check("bp_flags",  {inv0, inx0}, 2'b01);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cur_res !== r0 || cur_inv !== inv0 || cur_inx !== inx0 ||
          cur_out_valid !== 1'b1 || cur_in_ready !== 1'b0) bad++;
    end
    check("bp_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", cur_out_valid, 0);
    check("bp_release_in_ready",  cur_in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid();
    check("bp_next_result", cur_res, 32'h40400000);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // ---- reset in the middle of ITER drops the op ----
    op       = 32'h40000000;
    in_valid = 1'b1;
    wait_in_ready();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", cur_out_valid, 0);
    check("midrst_in_ready",  cur_in_ready, 0);
    check("midrst_state",     cur_st, IDLE);
    reset = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (cur_out_valid) seen = 1;
    end
    check("midrst_no_output", seen, 0);
    run_op(32'h41100000, 0, r, inv, inx, lat);
    check("midrst_next_result", r, 32'h40400000);
    check("midrst_next_flags",  {inv, inx}, 2'b00);

    // ---- randomized against the reference model ----
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < ((s == 0) ? 500 : (s == 1) ? 2500 : 2000); i++) begin
        logic [31:0] x;
        x = gen_op();
        m = ref_sqrt(x);
        run_op(x, $urandom_range(0, 2), r, inv, inx, lat);
        if ({inv, inx, r} !== m)
          $display("FAIL rand_value (sel=%0d op=%h): got %h expected %h", s, x, {inv, inx, r}, m);
        check("rand_value",   {inv, inx, r}, m);
        check("rand_latency", lat, exp_lat(s, tb_special(x)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
